// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  // 50 MHz / 115200 baud, shared with the transmitter
  localparam int UART_CLKS_PER_BIT = 434;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous level, resets high
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages reset to 1 so an idle-high line never looks like an edge out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver for the USB-RS232 link
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usb_rs232_rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic              rxs;
  rx_state_e         state, state_nx;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_nx;
  logic [2:0]        bit_idx, bit_idx_nx;
  logic [DATA_W-1:0] shift_reg, shift_nx;
  logic [DATA_W-1:0] rx_data_nx;
  logic              valid_nx, err_nx;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (usb_rs232_rxd),
    .q   (rxs)
  );

  // State, counters, shifter and registered output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_nx;
      clk_cnt      <= clk_cnt_nx;
      bit_idx      <= bit_idx_nx;
      shift_reg    <= shift_nx;
      rx_data      <= rx_data_nx;
      rx_valid     <= valid_nx;
      rx_frame_err <= err_nx;
    end
  end

  // Frame sequencing: each phase samples rxs on its last cycle
  always_comb begin
    state_nx   = state;
    clk_cnt_nx = clk_cnt + CNT_W'(1);
    bit_idx_nx = bit_idx;
    shift_nx   = shift_reg;
    rx_data_nx = rx_data;
    valid_nx   = 1'b0;
    err_nx     = 1'b0;

    case (state)
      RX_IDLE: begin
        clk_cnt_nx = '0;
        if (!rxs) state_nx = RX_START;
      end
      RX_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nx = '0;
          if (rxs) begin
            state_nx = RX_IDLE;
          end else begin
            state_nx   = RX_DATA;
            bit_idx_nx = '0;
          end
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nx = '0;
          shift_nx   = {rxs, shift_reg[DATA_W-1:1]};
          if (bit_idx == 3'd7) state_nx = RX_STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nx = '0;
          if (rxs) begin
            rx_data_nx = shift_reg;
            valid_nx   = 1'b1;
            state_nx   = RX_IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        clk_cnt_nx = '0;
        if (rxs) state_nx = RX_IDLE;
      end
      default: begin
        clk_cnt_nx = '0;
        state_nx   = RX_IDLE;
      end
    endcase
  end

  assign rx_busy = (state != RX_IDLE);

endmodule
